instruction_encoder: RTL
========================

// Module: instruction_encoder
// PURPOSE
//  Turns instruction field tuples into 16-bit VR16 words, as the inverse of instruction_decoder.
//  Sits between the host/debug program loader and the instruction-memory write port.
//  Encoded words are buffered in a FIFO and emitted with ascending program addresses.
//  Accepting a HALT seals the program; a new start pulse is then required.
// PARAMETERS
//  FIFO_DEPTH  4     encoded-word buffer entries (power of 2, >=2)
//  PROG_DEPTH  4096  max program length in words; address width = 12
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  start      in   1   1-cycle pulse: clear address/errors, enter RUN
//  in_valid   in   1   field tuple valid
//  in_ready   out  1   encoder can accept tuple
//  in_opcode  in   4   opcode
//  in_rd      in   2   store_at / reg_to_work_on
//  in_rs1     in   2   operand_one
//  in_rs2     in   2   operand_two
//  in_imm     in   12  imm10 / imm8 / jump address (zero-extended by host)
//  out_valid  out  1   out_instr/out_addr valid
//  out_ready  in   1   memory writer accepts word
//  out_instr  out  16  encoded instruction
//  out_addr   out  12  program address of out_instr
//  busy       out  1   state != IDLE or FIFO non-empty
//  done       out  1   SEALED and FIFO empty (level)
//  err_imm    out  1   sticky: immediate had bits set above field width
//  err_ovf    out  1   sticky: program exceeded PROG_DEPTH
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, addr counter=0; every output 0 (in_ready=0, out_*=0).
//  Formats ([15:12]=opcode always; unused bits forced 0):
//   R 0,2,4,6,B,C,D,E: [11:10]=rd [9:8]=rs1 [7:6]=rs2 [5:0]=0
//   I 1,3,5,7: [11:10]=rd [9:0]=imm[9:0]; err_imm if imm[11:10]!=0
//   STOREI 8: [11:10]=0 [9:8]=rd [7:0]=imm[7:0]; err_imm if imm[11:8]!=0
//   JUMP 9: [11:0]=imm;  DELETE A: [11:10]=rd [9:0]=0;  HALT F: [11:0]=0
//  Invalid immediate: the word is still encoded (truncated) and the error flag is set sticky.
//  Handshake: transfer when valid&ready on the same edge; valid must hold until ready.
//   out_instr/out_addr are stable while out_valid&!out_ready.
//  in_ready = (state==RUN) & !fifo_full; this is combinational from registered state only.
//  Latency: tuple accepted at edge N -> out_valid at earliest after edge N+1 (registered FIFO).
//  Address: write counter stamps each pushed word and increments on push.
//   out_addr is carried through the FIFO alongside the word.
//  FSM:
//   IDLE   -start->  RUN  (addr=0, err_*=0; FIFO contents left to drain)
//   RUN    -push HALT-> SEALED
//   RUN    -push at addr==PROG_DEPTH-1 (non-HALT)-> SEALED, set err_ovf (word still pushed)
//   SEALED -FIFO empty & start-> RUN (clear as above)
//   SEALED: in_ready=0; done=1 once FIFO is empty.
//  start in RUN: restarts the address at 0 and clears errors, but does not flush the FIFO.
//  start in IDLE with a non-empty FIFO is legal.
//  start in SEALED while the FIFO is non-empty: ignored.
//  FIFO full: in_ready=0; simultaneous pop frees the slot from the next cycle only.
//   Push and pop may both occur on the same edge when not full.
//  Empty FIFO: out_valid=0, out_instr holds its last value.
//  Reset mid-stream: FIFO discarded, no further out_valid, state=IDLE.
// STRUCTURE
//  Shared package vr16_isa_pkg holds:
//   opcode localparams (OP_ADD..OP_HALT)
//   field msb/lsb constants (RD_HI/LO, RS1, RS2, IMM10, IMM8, JADDR)
//   function is_rtype/is_itype
//  Sub-module instr_fifo: sync FIFO, width 28 (16 instr + 12 addr), depth FIFO_DEPTH.
//   Ports: push/pop/full/empty/count.
//  Top level: encoder mux (combinational), FSM, address counter, sticky errors.
// TESTING
//  1 start; push ADD rd=1 rs1=2 rs2=3 -> out_instr=16'h06C0 out_addr=0 after 1 cycle.
//  2 ADDI rd=2 imm=12'h3FF -> 16'h1BFF; SUBI rd=0 imm=12'h400 -> 16'h3000 with err_imm=1.
//   err_imm stays 1 until the next start.
//  3 STOREI rd=3 imm=8'hA5 -> 16'h83A5; JUMP imm=12'hABC -> 16'h9ABC.
//   DELETE rd=2 -> 16'hA800; HALT -> 16'hF000.
//   After HALT: in_ready=0; done=1 when drained.
//  4 out_ready=0; push 5 words with FIFO_DEPTH=4 -> in_ready drops after 4 pushes.
//   Then release out_ready: addrs 0..4 come out in order, no loss or duplication.
//  5 PROG_DEPTH=4: push 5 ADDs -> 4th push seals (err_ovf=1) and the 5th is blocked.
//   done=1 after drain; start then resumes at addr 0 with errors cleared.
//  6 Assert reset with 2 words queued -> all outputs 0 next sample.
//   The next start+push emits addr 0 first.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// VR16 ISA constants shared by the encoder (and its decoder counterpart):
// opcodes, field positions, format predicates, and the encoder FSM state type.
package vr16_isa_pkg;

    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int ENTRY_W = WORD_W + ADDR_W;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_ADDI   = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_SUBI   = 4'h3;
    localparam logic [3:0] OP_AND    = 4'h4;
    localparam logic [3:0] OP_ANDI   = 4'h5;
    localparam logic [3:0] OP_OR     = 4'h6;
    localparam logic [3:0] OP_ORI    = 4'h7;
    localparam logic [3:0] OP_STOREI = 4'h8;
    localparam logic [3:0] OP_JUMP   = 4'h9;
    localparam logic [3:0] OP_DELETE = 4'hA;
    localparam logic [3:0] OP_XOR    = 4'hB;
    localparam logic [3:0] OP_NOT    = 4'hC;
    localparam logic [3:0] OP_SHL    = 4'hD;
    localparam logic [3:0] OP_SHR    = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    // Field positions inside the 16-bit word
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 10;
    localparam int RS1_HI   = 9;
    localparam int RS1_LO   = 8;
    localparam int RS2_HI   = 7;
    localparam int RS2_LO   = 6;
    localparam int IMM10_HI = 9;
    localparam int IMM10_LO = 0;
    localparam int IMM8_HI  = 7;
    localparam int IMM8_LO  = 0;
    localparam int JADDR_HI = 11;
    localparam int JADDR_LO = 0;
    // STOREI places its register in the rs1 slot
    localparam int SRD_HI   = 9;
    localparam int SRD_LO   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SEALED = 2'd2
    } enc_state_t;

    function automatic logic is_rtype(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL, OP_SHR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_itype(input logic [3:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Loader-side tuple handshake and memory-writer-side word handshake.
interface instruction_encoder_if;
    import vr16_isa_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [1:0]        in_rd;
    logic [1:0]        in_rs1;
    logic [1:0]        in_rs2;
    logic [ADDR_W-1:0] in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// Synchronous FIFO with a registered head stage: a pushed entry lands in
// storage first and reaches the head register one edge later, so the
// consumer never sees a word in the same cycle it was written.
// count/full/empty include the head register.
module instr_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       head_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic [WIDTH-1:0] head_q;
    logic             head_vld;
    logic             load;

    assign load = (mem_cnt != '0) && (!head_vld || pop);

    // Storage write; contents need no reset because mem_cnt gates reads
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointer and storage occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (load) rd_ptr <= rd_ptr + PW'(1);
            mem_cnt <= mem_cnt + CW'(push) - CW'(load);
        end
    end

    // Head register: refilled from storage when empty or being popped; holds last word otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            head_vld <= 1'b0;
        end else if (load) begin
            head_q   <= mem[rd_ptr];
            head_vld <= 1'b1;
        end else if (pop) begin
            head_vld <= 1'b0;
        end
    end

    assign count      = mem_cnt + CW'(head_vld);
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign pop_data   = head_q;
    assign head_valid = head_vld;

endmodule

// File: rtl/instruction_encoder.sv
// VR16 instruction encoder: field tuples in, encoded words with ascending
// program addresses out through a small FIFO. Accepting HALT, or filling the
// last program address, seals the program until the next start.
//
//  state     | meaning
//  ST_IDLE   | after reset, waiting for start
//  ST_RUN    | accepting tuples, stamping addresses
//  ST_SEALED | program closed; start honoured only once the FIFO is empty
module instruction_encoder
    import vr16_isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PROG_DEPTH = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instruction_encoder_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err_imm,
    output logic                 err_ovf
);

    localparam int                CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

    enc_state_t         state;
    enc_state_t         state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORD_W-1:0]  enc_word;
    logic               imm_bad;
    logic               in_ready;
    logic               push;
    logic               pop;
    logic               restart;
    logic               seal_ovf;
    logic               fifo_full;
    logic               fifo_empty;
    logic               head_valid;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] head_data;

    // Field-to-word encoder; out-of-range immediates are truncated and flagged
    always_comb begin
        enc_word                = '0;
        imm_bad                 = 1'b0;
        enc_word[OPC_HI:OPC_LO] = bus.in_opcode;
        if (is_rtype(bus.in_opcode)) begin
            enc_word[RD_HI:RD_LO]   = bus.in_rd;
            enc_word[RS1_HI:RS1_LO] = bus.in_rs1;
            enc_word[RS2_HI:RS2_LO] = bus.in_rs2;
        end else if (is_itype(bus.in_opcode)) begin
            enc_word[RD_HI:RD_LO]       = bus.in_rd;
            enc_word[IMM10_HI:IMM10_LO] = bus.in_imm[9:0];
            imm_bad                     = |bus.in_imm[11:10];
        end else begin
            case (bus.in_opcode)
                OP_STOREI: begin
                    enc_word[SRD_HI:SRD_LO]   = bus.in_rd;
                    enc_word[IMM8_HI:IMM8_LO] = bus.in_imm[7:0];
                    imm_bad                   = |bus.in_imm[11:8];
                end
                OP_JUMP:   enc_word[JADDR_HI:JADDR_LO] = bus.in_imm;
                OP_DELETE: enc_word[RD_HI:RD_LO]       = bus.in_rd;
                default:   ;
            endcase
        end
    end

    assign in_ready     = (state == ST_RUN) && !fifo_full;
    assign bus.in_ready = in_ready;
    assign push         = bus.in_valid && in_ready;
    assign pop          = head_valid && bus.out_ready;
    // A start in SEALED is dropped while words are still queued
    assign restart      = start && ((state != ST_SEALED) || fifo_empty);

    // Next-state: seal on HALT or on a push into the final program address
    always_comb begin
        state_nxt = state;
        seal_ovf  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (push) begin
                    if (bus.in_opcode == OP_HALT) begin
                        state_nxt = ST_SEALED;
                    end else if (addr_q == LAST_ADDR) begin
                        state_nxt = ST_SEALED;
                        seal_ovf  = 1'b1;
                    end
                end
            end
            ST_SEALED: begin
                if (start && fifo_empty) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Address counter and sticky error flags; restart takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            err_imm <= 1'b0;
            err_ovf <= 1'b0;
        end else if (restart) begin
            addr_q  <= '0;
            err_imm <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (push)            addr_q  <= addr_q + ADDR_W'(1);
            if (push && imm_bad) err_imm <= 1'b1;
            if (seal_ovf)        err_ovf <= 1'b1;
        end
    end

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({enc_word, addr_q}),
        .pop        (pop),
        .pop_data   (head_data),
        .head_valid (head_valid),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign bus.out_valid = head_valid;
    assign bus.out_instr = head_data[ENTRY_W-1:ADDR_W];
    assign bus.out_addr  = head_data[ADDR_W-1:0];
    assign busy          = (state != ST_IDLE) || (fifo_count != '0);
    assign done          = (state == ST_SEALED) && fifo_empty;

endmodule
